serial_vote_counter: RTL and testbench

Parametrised successor to the team's 4-input any/all/exactly-two evaluator. Latches an N-bit vote vector on a start strobe and counts its ones serially, one bit per clock. It then reports the count and registered flags: any-one, all-ones, exactly-K and at-least-K, with K chosen at run time. The block serves as a reusable majority/quorum detector in lab datapaths that have a start/done control unit.

---
 rtl/serial_vote_counter.sv | 164 ++++++++++++++++
 tb/tb_serial_vote_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_vote_counter.sv
// -----------------------------------------------------------------------------
// serial_vote_counter
//
// Purpose:
//   Quorum/majority detector. A start strobe latches an N-bit vote vector and
//   a target count K. The ones in the vector are then counted serially, one
//   bit per clock. When the last bit is processed, the popcount is registered
//   together with four flags: any-one, all-ones, exactly-K and at-least-K.
//   A one-cycle done pulse then marks the results as valid.
//
//   Timing: start accepted at edge E0, bits processed at E1..EN, done high
//   during the cycle after EN. One evaluation every N+2 cycles.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   start   in   1   request evaluation (only honoured in IDLE)
//   data_in in   N   vote vector, sampled on the accepting edge
//   k_in    in   CW  target count K, sampled on the accepting edge
//   busy    out  1   high while bits are being counted
//   done    out  1   one-cycle pulse, results valid
//   count   out  CW  number of ones in the latched vector
//   any_o   out  1   count >= 1
//   all_o   out  1   count == N
//   eq_k    out  1   count == K
//   ge_k    out  1   count >= K
// -----------------------------------------------------------------------------
module serial_vote_counter #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [N-1:0]  data_in,
   input  logic [CW-1:0] k_in,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count,
   output logic          any_o,
   output logic          all_o,
   output logic          eq_k,
   output logic          ge_k
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
   localparam logic [CW-1:0] N_CW     = CW'(N);

   state_t          state;
   state_t          state_nxt;

   logic [N-1:0]    shift_r;
   logic [CW-1:0]   acc;
   logic [CW-1:0]   bit_idx;
   logic [CW-1:0]   k_r;

   logic            last_bit;
   logic [CW-1:0]   sum;
   logic [3:0]      flags_nxt;

   // Flag evaluation on the final sum; comparisons are unsigned on CW bits.
   // Packed as {any, all, eq, ge}.
   function automatic logic [3:0] eval_flags(input logic [CW-1:0] s,
                                             input logic [CW-1:0] k);
      logic f_any;
      logic f_all;
      logic f_eq;
      logic f_ge;
      f_any = (s != '0);
      f_all = (s == N_CW);
      f_eq  = (s == k);
      f_ge  = (s >= k);
      return {f_any, f_all, f_eq, f_ge};
   endfunction

   // The accumulator cannot overflow: its largest value is N, which fits in CW.
   assign sum       = acc + CW'(shift_r[0]);
   assign last_bit  = (state == SHIFT) && (bit_idx == LAST_IDX);
   assign flags_nxt = eval_flags(sum, k_r);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control outputs (Moore, decoded from state)
   // ---------------------------------------------------------------------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         SHIFT:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: capture on accept, serial accumulate, register results on the
   // final bit. Results hold until the next evaluation completes, so they stay
   // stable while busy.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_r <= '0;
         acc     <= '0;
         bit_idx <= '0;
         k_r     <= '0;
         count   <= '0;
         any_o   <= 1'b0;
         all_o   <= 1'b0;
         eq_k    <= 1'b0;
         ge_k    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shift_r <= data_in;
                  k_r     <= k_in;
                  acc     <= '0;
                  bit_idx <= '0;
               end
            end
            SHIFT: begin
               acc     <= sum;
               shift_r <= shift_r >> 1;
               bit_idx <= bit_idx + CW'(1);
               if (last_bit) begin
                  count                      <= sum;
                  {any_o, all_o, eq_k, ge_k} <= flags_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_vote_counter.sv
// -----------------------------------------------------------------------------
// tb_serial_vote_counter
//
// Directed bench for serial_vote_counter. Three instances (N=4, N=1, N=7)
// share clock and reset. The N=4 instance runs the hand-computed scenarios;
// the N=1 and N=7 instances are swept over every vote vector and every
// representable K, against a popcount reference.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_serial_vote_counter;

   logic clk;
   logic rst;

   // N = 4 instance
   logic       st4;
   logic [3:0] d4;
   logic [2:0] k4;
   logic       busy4, done4, any4, all4, eq4, ge4;
   logic [2:0] cnt4;

   // N = 1 instance
   logic       st1;
   logic [0:0] d1;
   logic [0:0] k1;
   logic       busy1, done1, any1, all1, eq1, ge1;
   logic [0:0] cnt1;

   // N = 7 instance
   logic       st7;
   logic [6:0] d7;
   logic [2:0] k7;
   logic       busy7, done7, any7, all7, eq7, ge7;
   logic [2:0] cnt7;

   int n_cmp;
   int n_err;

   serial_vote_counter #(.N(4)) dut4 (
      .clk(clk), .rst(rst), .start(st4), .data_in(d4), .k_in(k4),
      .busy(busy4), .done(done4), .count(cnt4),
      .any_o(any4), .all_o(all4), .eq_k(eq4), .ge_k(ge4)
   );

   serial_vote_counter #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .start(st1), .data_in(d1), .k_in(k1),
      .busy(busy1), .done(done1), .count(cnt1),
      .any_o(any1), .all_o(all1), .eq_k(eq1), .ge_k(ge1)
   );

   serial_vote_counter #(.N(7)) dut7 (
      .clk(clk), .rst(rst), .start(st7), .data_in(d7), .k_in(k7),
      .busy(busy7), .done(done7), .count(cnt7),
      .any_o(any7), .all_o(all7), .eq_k(eq7), .ge_k(ge7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One evaluation on the N=4 instance; caller is at a falling edge.
   // With disturb set, start is re-pulsed and data_in/k_in changed during SHIFT.
   task automatic run4(input logic [3:0] d, input logic [2:0] k,
                       input int e_cnt, input bit e_any, input bit e_all,
                       input bit e_eq, input bit e_ge, input bit disturb);
      logic [2:0] prev;
      int lat;
      int extra;
      prev = cnt4;
      st4 = 1'b1; d4 = d; k4 = k;
      @(negedge clk);
      st4 = 1'b0;
      lat = 0;
      while (done4 !== 1'b1 && lat < 12) begin
         chk("busy_during_shift", busy4, 1);
         chk("count_hold", cnt4, prev);
         if (disturb && lat < 2) begin
            st4 = 1'b1; d4 = 4'b1111; k4 = 3'd4;
         end else begin
            st4 = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      chk("done_latency", lat, 4);
      chk("busy_at_done", busy4, 0);
      chk("count", cnt4, e_cnt);
      chk("any_o", any4, e_any);
      chk("all_o", all4, e_all);
      chk("eq_k", eq4, e_eq);
      chk("ge_k", ge4, e_ge);
      @(negedge clk);
      chk("done_one_cycle", done4, 0);
      if (disturb) begin
         extra = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 === 1'b1 || busy4 === 1'b1) extra++;
         end
         chk("no_second_run", extra, 0);
         chk("count_after_ignored_start", cnt4, e_cnt);
      end
   endtask

   // Sweep run on the N=1 (which=1) or N=7 (which=7) instance against popcount.
   task automatic run_sw(input int which, input int d, input int k);
      int lat;
      int pc;
      int nn;
      logic [31:0] o_cnt, o_any, o_all, o_eq, o_ge;
      nn = which;
      if (which == 1) begin
         st1 = 1'b1; d1 = d[0:0]; k1 = k[0:0];
      end else begin
         st7 = 1'b1; d7 = d[6:0]; k7 = k[2:0];
      end
      @(negedge clk);
      st1 = 1'b0; st7 = 1'b0;
      lat = 0;
      while (((which == 1) ? done1 : done7) !== 1'b1 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      if (which == 1) begin
         o_cnt = 32'(cnt1); o_any = 32'(any1); o_all = 32'(all1);
         o_eq = 32'(eq1); o_ge = 32'(ge1);
      end else begin
         o_cnt = 32'(cnt7); o_any = 32'(any7); o_all = 32'(all7);
         o_eq = 32'(eq7); o_ge = 32'(ge7);
      end
      pc = $countones(d);
      chk("sweep_latency", lat, nn);
      chk("sweep_count", o_cnt, pc);
      chk("sweep_any", o_any, (pc != 0) ? 1 : 0);
      chk("sweep_all", o_all, (pc == nn) ? 1 : 0);
      chk("sweep_eq", o_eq, (pc == k) ? 1 : 0);
      chk("sweep_ge", o_ge, (pc >= k) ? 1 : 0);
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      st4 = 1'b0; d4 = '0; k4 = '0;
      st1 = 1'b0; d1 = '0; k1 = '0;
      st7 = 1'b0; d7 = '0; k7 = '0;
      #1;
      chk("rst_busy", busy4, 0);
      chk("rst_done", done4, 0);
      chk("rst_count", cnt4, 0);
      chk("rst_flags", {any4, all4, eq4, ge4}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Basic runs with hand-computed results
      run4(4'b1100, 3'd2, 2, 1, 0, 1, 1, 0);
      run4(4'b0000, 3'd0, 0, 0, 0, 1, 1, 0);
      run4(4'b1111, 3'd3, 4, 1, 1, 0, 1, 0);
      run4(4'b0001, 3'd7, 1, 1, 0, 0, 0, 0);

      // Start re-pulsed and inputs changed during SHIFT: no effect
      run4(4'b1010, 3'd2, 2, 1, 0, 1, 1, 1);

      // Reset in the middle of SHIFT
      run4(4'b0111, 3'd3, 3, 1, 0, 1, 1, 0);
      st4 = 1'b1; d4 = 4'b1111; k4 = 3'd3;
      @(negedge clk);
      st4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_abort_busy", busy4, 1);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy4, 0);
      chk("abort_done", done4, 0);
      chk("abort_count", cnt4, 0);
      chk("abort_flags", {any4, all4, eq4, ge4}, 0);
      @(negedge clk);
      chk("abort_done_held", done4, 0);
      rst = 1'b0;
      run4(4'b0110, 3'd1, 2, 1, 0, 0, 1, 0);

      // Exhaustive sweeps on the N=1 and N=7 instances
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 2; k++)
            run_sw(1, d, k);
      for (int d = 0; d < 128; d++)
         for (int k = 0; k < 8; k++)
            run_sw(7, d, k);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
